// File: rtl/data_mem_pkg.sv
// ============================================================================
// Module      : data_mem_pkg
// Description : Shared types, funct3 encodings and size decode for the
//               multi-cycle data memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_pkg;

  // Responder handshake states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // RV64 load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Access size in bytes: 1, 2, 4 or 8
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_load_extract.sv
// ============================================================================
// Module      : load_extract
// Description : Selects the addressed bytes from a little-endian 64-bit word
//               and sign- or zero-extends them according to funct3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extract
  import data_mem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] shifted;

  // Bring the addressed byte lane down to bit 0
  assign shifted = word >> {offset, 3'b000};

  // Extend the selected field to 64 bits
  always_comb begin
    result = 64'd0;
    case (funct3)
      F3_B:    result = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    result = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    result = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    result = shifted;
      F3_BU:   result = {56'd0, shifted[7:0]};
      F3_HU:   result = {48'd0, shifted[15:0]};
      F3_WU:   result = {32'd0, shifted[31:0]};
      default: result = 64'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : Multi-cycle byte-addressed 64-bit data memory for the MEM
//               stage. valid/ready request, one-cycle response pulse, stall
//               output, alignment/range/funct3 error detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int ADDR_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               cap_write;
  logic [63:0]        cap_addr;
  logic [63:0]        cap_wdata;
  logic [2:0]         cap_funct3;

  logic [7:0]         mem [DEPTH_BYTES];

  logic [ADDR_W-4:0]  word_base;
  logic [63:0]        rd_word;
  logic [63:0]        load_value;
  logic [3:0]         acc_size;
  logic [7:0]         size_mask;
  logic [7:0]         byte_en;
  logic [63:0]        store_data;
  logic               misaligned;
  logic               out_of_range;
  logic               illegal_f3;
  logic               access_err;
  logic               last_edge;
  logic               wr_fire;

  assign req_ready = (state == IDLE);
  assign stall     = ((state == IDLE) && req_valid) || (state == BUSY);

  assign word_base = cap_addr[ADDR_W-1:3];
  assign acc_size  = size_bytes(cap_funct3);

  // Assemble the aligned 64-bit word containing the access
  for (genvar k = 0; k < 8; k++) begin : g_rd_lane
    assign rd_word[8*k +: 8] = mem[{word_base, 3'(k)}];
  end

  load_extract u_load_extract (
    .word   (rd_word),
    .offset (cap_addr[2:0]),
    .funct3 (cap_funct3),
    .result (load_value)
  );

  // Alignment check and byte-lane mask per access size
  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'hFF;
    case (cap_funct3[1:0])
      2'd0: begin misaligned = 1'b0;            size_mask = 8'h01; end
      2'd1: begin misaligned = cap_addr[0];     size_mask = 8'h03; end
      2'd2: begin misaligned = |cap_addr[1:0];  size_mask = 8'h0F; end
      default: begin misaligned = |cap_addr[2:0]; size_mask = 8'hFF; end
    endcase
  end

  // 65-bit sum so addresses near 2^64 cannot wrap into range
  assign out_of_range = ({1'b0, cap_addr} + 65'(acc_size)) > 65'(DEPTH_BYTES);
  assign illegal_f3   = cap_write ? cap_funct3[2] : (cap_funct3 == 3'b111);
  assign access_err   = misaligned || out_of_range || illegal_f3;

  assign byte_en    = size_mask << cap_addr[2:0];
  assign store_data = cap_wdata << {cap_addr[2:0], 3'b000};

  assign last_edge = (state == BUSY) && (cnt == '0);
  assign wr_fire   = last_edge && cap_write && !access_err;

  // Byte-enabled store; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int k = 0; k < 8; k++) begin
        if (byte_en[k]) begin
          mem[{word_base, 3'(k)}] <= store_data[8*k +: 8];
        end
      end
    end
  end

  // Request/response FSM with latency counter and registered response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_write  <= 1'b0;
      cap_addr   <= 64'd0;
      cap_wdata  <= 64'd0;
      cap_funct3 <= 3'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            cap_write  <= req_write;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            cap_funct3 <= req_funct3;
            cnt        <= CNT_W'(LATENCY - 1);
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= access_err;
            resp_rdata <= (access_err || cap_write) ? 64'd0 : load_value;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder with a byte-array
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  localparam int DEPTH   = 256;
  localparam int LAT     = 2;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_valid1;
  logic        req_write;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready, resp_valid, resp_err, stall;
  logic [63:0] resp_rdata;
  logic        ready1, rv1, err1, stall1;
  logic [63:0] rd1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall)
  );

  data_mem_responder #(.DEPTH_BYTES(64), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .resp_valid(rv1), .resp_rdata(rd1),
    .resp_err(err1), .stall(stall1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: size, alignment, range and funct3 rules applied to a byte array
  task automatic model(input bit wr, input logic [63:0] a, input logic [63:0] wd,
                       input logic [2:0] f3, output bit e, output logic [63:0] rd);
    int          sz;
    logic [64:0] lim;
    sz  = 1 << f3[1:0];
    lim = {1'b0, a} + 65'(sz);
    e   = ((a % 64'(sz)) != 0) || (lim > 65'(DEPTH)) || (wr ? f3[2] : (f3 == 3'b111));
    rd  = 64'd0;
    if (!e) begin
      if (wr) begin
        for (int i = 0; i < sz; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) rd[8*i +: 8] = ref_mem[int'(a) + i];
        if (!f3[2] && sz < 8 && rd[8*sz-1]) rd = rd | (~64'd0 << (8*sz));
      end
    end
  endtask

  // One full request/response transaction; entered and left at posedge+1
  task automatic access(input bit wr, input logic [63:0] a, input logic [63:0] wd,
                        input logic [2:0] f3, input string tag,
                        output logic [63:0] rd_o, output logic err_o);
    bit          e;
    logic [63:0] rd;
    int          n, sc;
    model(wr, a, wd, f3, e, rd);
    req_write = wr; req_addr = a; req_wdata = wd; req_funct3 = f3; req_valid = 1'b1;
    #1;
    check({tag, " ready"}, 64'(req_ready), 64'd1);
    check({tag, " stall_idle"}, 64'(stall), 64'd1);
    @(posedge clk); #1;
    n = 0; sc = 0;
    while (resp_valid !== 1'b1 && n < TIMEOUT) begin
      if (stall === 1'b1) sc++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(LAT));
    check({tag, " stall_cycles"}, 64'(sc), 64'(LAT));
    check({tag, " err"}, 64'(resp_err), 64'(e));
    check({tag, " rdata"}, resp_rdata, rd);
    check({tag, " stall_resp"}, 64'(stall), 64'd0);
    rd_o  = resp_rdata;
    err_o = resp_err;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, " pulse_end"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [63:0] a, wd;
    logic [2:0]  f3;
    bit          w;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_valid1 = 1'b0; req_write = 1'b0;
    req_addr = 64'd0; req_wdata = 64'd0; req_funct3 = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst rdata", resp_rdata, 64'd0);
    check("rst err", 64'(resp_err), 64'd0);
    check("rst ready", 64'(req_ready), 64'd1);
    check("rst stall_lo", 64'(stall), 64'd0);
    req_valid = 1'b1; #1;
    check("rst stall_hi", 64'(stall), 64'd1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed accesses
    access(1, 64'd8, 64'h1122334455667788, 3'b011, "sd8", rd, er);
    access(0, 64'd8, 64'd0, 3'b011, "ld8", rd, er);
    check("ld8 const", rd, 64'h1122334455667788);
    access(0, 64'd8, 64'd0, 3'b000, "lb8", rd, er);
    check("lb8 const", rd, 64'hFFFFFFFFFFFFFF88);
    access(0, 64'd8, 64'd0, 3'b100, "lbu8", rd, er);
    check("lbu8 const", rd, 64'h88);
    access(0, 64'd10, 64'd0, 3'b001, "lh10", rd, er);
    check("lh10 const", rd, 64'h5566);
    access(0, 64'd12, 64'd0, 3'b010, "lw12", rd, er);
    check("lw12 const", rd, 64'h11223344);
    access(1, 64'd9, 64'hAB, 3'b000, "sb9", rd, er);
    access(0, 64'd8, 64'd0, 3'b011, "ld8b", rd, er);
    check("ld8b const", rd, 64'h112233445566AB88);
    access(0, 64'd6, 64'd0, 3'b010, "lw6", rd, er);
    check("lw6 err", 64'(er), 64'd1);
    access(1, 64'd2, 64'hFFFFFFFF, 3'b010, "sw2", rd, er);
    check("sw2 err", 64'(er), 64'd1);
    access(0, 64'd0, 64'd0, 3'b011, "ld0", rd, er);
    check("ld0 const", rd, 64'd0);
    access(0, 64'd0, 64'd0, 3'b111, "f3_111", rd, er);
    check("f3_111 err", 64'(er), 64'd1);
    access(0, 64'd256, 64'd0, 3'b011, "ld256", rd, er);
    check("ld256 err", 64'(er), 64'd1);
    access(0, 64'hFFFFFFFFFFFFFFF8, 64'd0, 3'b011, "ldtop", rd, er);
    check("ldtop err", 64'(er), 64'd1);
    access(0, 64'd248, 64'd0, 3'b011, "ld248", rd, er);
    check("ld248 err", 64'(er), 64'd0);

    // Reset asserted while a store is in flight
    req_write = 1'b1; req_addr = 64'd16; req_wdata = 64'hDEAD; req_funct3 = 3'b011;
    req_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    check("midrst ready", 64'(req_ready), 64'd1);
    check("midrst resp_valid", 64'(resp_valid), 64'd0);
    check("midrst rdata", resp_rdata, 64'd0);
    check("midrst err", 64'(resp_err), 64'd0);
    check("midrst stall_hi", 64'(stall), 64'd1);
    req_valid = 1'b0; #1;
    check("midrst stall_lo", 64'(stall), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    access(0, 64'd16, 64'd0, 3'b011, "ld16", rd, er);
    check("ld16 const", rd, 64'd0);

    // req_valid held high: IDLE, BUSY, BUSY, RESP repeating
    req_write = 1'b0; req_addr = 64'd0; req_funct3 = 3'b011; req_valid = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk); #1;
      check($sformatf("hold rv j%0d", j), 64'(resp_valid), 64'((j % 4) == 3));
      check($sformatf("hold stall j%0d", j), 64'(stall), 64'((j % 4) != 3));
    end
    req_valid = 1'b0;
    @(posedge clk); #1;

    // LATENCY=1 instance: IDLE, BUSY, RESP repeating
    req_valid1 = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      check($sformatf("lat1 rv j%0d", j), 64'(rv1), 64'((j % 3) == 2));
      check($sformatf("lat1 stall j%0d", j), 64'(stall1), 64'((j % 3) != 2));
      check($sformatf("lat1 ready j%0d", j), 64'(ready1), 64'((j % 3) == 0));
    end
    req_valid1 = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    for (int t = 0; t < 60; t++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       a = {$urandom, $urandom};
        1, 2:    a = 64'($urandom_range(0, DEPTH + 7));
        default: a = 64'($urandom_range(0, DEPTH - 1)) & ~64'((1 << f3[1:0]) - 1);
      endcase
      access(w, a, wd, f3, $sformatf("rnd%0d", t), rd, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
